// File: rtl/neander_core_p.sv
// Neander accumulator CPU: internal program/data memory, HALTED run control, host load/inspect port.
// Optional carry flag and JC (opcode B) enabled by defining NEANDER_CARRY_EN.
module neander_core_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic [DATA_W-1:0] o_ld_rdata,
  output logic [DATA_W-1:0] o_acc,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_n,
  output logic              o_z,
  output logic              o_c,
  output logic              o_halted
);

  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    S_HALTED, S_F0, S_F1, S_F2, S_DEC, S_RD, S_AD, S_EX0, S_EX1, S_JP
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] acc, rdm, alu_res, add_res, mem_wdata;
  logic [ADDR_W-1:0] pc, rem, mem_waddr;
  logic [3:0]        op;
  logic              n_flag, z_flag, c_flag;
  logic              is_mem_op, is_jump, jc_op, jmp_taken, mem_we;

  assign is_mem_op = (op >= OP_STA) && (op <= OP_AND);

`ifdef NEANDER_CARRY_EN
  logic [DATA_W:0] sum;
  assign sum     = {1'b0, acc} + {1'b0, rdm};
  assign add_res = sum[DATA_W-1:0];
  assign jc_op   = (op == 4'hB);

  always_ff @(posedge i_clk) begin
    if (i_rst)
      c_flag <= 1'b0;
    else if (state == S_EX1 && op == OP_ADD)
      c_flag <= sum[DATA_W];
  end
`else
  assign add_res = acc + rdm;
  assign jc_op   = 1'b0;
  assign c_flag  = 1'b0;
`endif

  assign is_jump   = (op == OP_JMP) || (op == OP_JN) || (op == OP_JZ) || jc_op;
  assign jmp_taken = (op == OP_JMP) || (op == OP_JN && n_flag) ||
                     (op == OP_JZ && z_flag) || (jc_op && c_flag);

  always_comb begin
    alu_res = rdm;
    case (op)
      OP_ADD:  alu_res = add_res;
      OP_OR:   alu_res = acc | rdm;
      OP_AND:  alu_res = acc & rdm;
      default: alu_res = rdm;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= S_HALTED;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HALTED: if (i_run) state_nxt = S_F0;
      S_F0:     state_nxt = S_F1;
      S_F1:     state_nxt = S_F2;
      S_F2:     state_nxt = S_DEC;
      S_DEC: begin
        if (op == OP_HLT)
          state_nxt = S_HALTED;
        else if (is_mem_op || jmp_taken)
          state_nxt = S_RD;
        else
          state_nxt = S_F0;
      end
      S_RD:     state_nxt = is_jump ? S_JP : S_AD;
      S_AD:     state_nxt = S_EX0;
      S_EX0:    state_nxt = S_EX1;
      S_EX1:    state_nxt = S_F0;
      S_JP:     state_nxt = S_F0;
      default:  state_nxt = S_HALTED;
    endcase
  end

  // Only the opcode nibble of the instruction word is kept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc    <= '0;
      pc     <= '0;
      rem    <= '0;
      rdm    <= '0;
      op     <= '0;
      n_flag <= 1'b0;
      z_flag <= 1'b1;
    end else begin
      case (state)
        S_F0: rem <= pc;
        S_F1: begin
          rdm <= mem[rem];
          pc  <= pc + ADDR_W'(1);
        end
        S_F2: op <= rdm[DATA_W-1 -: 4];
        S_DEC: begin
          if (op == OP_NOT) begin
            acc    <= ~acc;
            n_flag <= ~acc[DATA_W-1];
            z_flag <= &acc;
          end else if (is_mem_op || jmp_taken) begin
            rem <= pc;
          end else if (is_jump) begin
            pc <= pc + ADDR_W'(1);
          end
        end
        S_RD: begin
          rdm <= mem[rem];
          if (!is_jump)
            pc <= pc + ADDR_W'(1);
        end
        S_AD:  rem <= rdm[ADDR_W-1:0];
        S_EX0: rdm <= (op == OP_STA) ? acc : mem[rem];
        S_EX1: begin
          if (op == OP_LDA || op == OP_ADD || op == OP_OR || op == OP_AND) begin
            acc    <= alu_res;
            n_flag <= alu_res[DATA_W-1];
            z_flag <= (alu_res == '0);
          end
        end
        S_JP:    pc <= rdm[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  // Host writes only land while HALTED, so they never collide with STA.
  assign mem_we    = !i_rst && ((state == S_HALTED && i_ld_we) || (state == S_EX1 && op == OP_STA));
  assign mem_waddr = (state == S_HALTED) ? i_ld_addr : rem;
  assign mem_wdata = (state == S_HALTED) ? i_ld_data : rdm;

  always_ff @(posedge i_clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_ld_rdata <= '0;
    else
      o_ld_rdata <= mem[i_ld_addr];
  end

  assign o_acc    = acc;
  assign o_pc     = pc;
  assign o_n      = n_flag;
  assign o_z      = z_flag;
  assign o_c      = c_flag;
  assign o_halted = (state == S_HALTED);

endmodule

// File: tb/tb_neander_core_p.sv
// Bench for neander_core_p: directed programs plus random memory images run against an instruction-level model.
module tb_neander_core_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, ld_we;
  logic [7:0] ld_addr, ld_data, ld_rdata, acc, pc;
  logic       n, z, c, halted;

  neander_core_p #(.DATA_W(8), .ADDR_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_ld_we(ld_we), .i_ld_addr(ld_addr),
    .i_ld_data(ld_data), .o_ld_rdata(ld_rdata), .o_acc(acc), .o_pc(pc),
    .o_n(n), .o_z(z), .o_c(c), .o_halted(halted)
  );

  logic        w_rst, w_run, w_we, w_n, w_z, w_c, w_halted;
  logic [9:0]  w_addr, w_pc;
  logic [15:0] w_data, w_rdata, w_acc;

  neander_core_p #(.DATA_W(16), .ADDR_W(10)) dut_w (
    .i_clk(clk), .i_rst(w_rst), .i_run(w_run), .i_ld_we(w_we), .i_ld_addr(w_addr),
    .i_ld_data(w_data), .o_ld_rdata(w_rdata), .o_acc(w_acc), .o_pc(w_pc),
    .o_n(w_n), .o_z(w_z), .o_c(w_c), .o_halted(w_halted)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All helpers start and end just after a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    ld_addr = a;
    @(negedge clk);
    d = ld_rdata;
  endtask

  task automatic run_wait(input int budget, output int cyc);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    cyc = 1;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Instruction-level reference model.
  logic [7:0] m_mem [256];
  logic [7:0] init  [256];
  logic [7:0] m_acc, m_pc;
  logic       m_n, m_z, m_c;

  task automatic model_run(output bit done, output int cyc);
    logic [7:0] ins, opd;
    logic [3:0] op;
    logic [8:0] s;
    bit         jc;
    done = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 150 && !done; k++) begin
      ins = m_mem[m_pc]; m_pc = m_pc + 8'd1; op = ins[7:4];
`ifdef NEANDER_CARRY_EN
      jc = (op == 4'hB);
`else
      jc = 1'b0;
`endif
      if (op >= 4'h1 && op <= 4'h5) begin
        opd = m_mem[m_pc]; m_pc = m_pc + 8'd1; cyc += 8;
        case (op)
          4'h1: m_mem[opd] = m_acc;
          4'h2: m_acc = m_mem[opd];
          4'h3: begin
            s = {1'b0, m_acc} + {1'b0, m_mem[opd]};
            m_acc = s[7:0];
`ifdef NEANDER_CARRY_EN
            m_c = s[8];
`endif
          end
          4'h4: m_acc = m_acc | m_mem[opd];
          default: m_acc = m_acc & m_mem[opd];
        endcase
        if (op != 4'h1) begin m_n = m_acc[7]; m_z = (m_acc == 8'h00); end
      end else if (op == 4'h6) begin
        m_acc = ~m_acc; m_n = m_acc[7]; m_z = (m_acc == 8'h00); cyc += 4;
      end else if (op == 4'h8 || (op == 4'h9 && m_n) || (op == 4'hA && m_z) || (jc && m_c)) begin
        m_pc = m_mem[m_pc]; cyc += 6;
      end else if (op == 4'h9 || op == 4'hA || jc) begin
        m_pc = m_pc + 8'd1; cyc += 4;
      end else begin
        cyc += 4;
        done = (op == 4'hF);
      end
    end
  endtask

  initial begin
    int         cyc, mcyc;
    bit         ok;
    logic [7:0] rv, sa, sp;
    logic       sn, sz, sc;

    rst = 1'b0; run = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    w_rst = 1'b1; w_run = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    @(negedge clk);
    do_reset();
    w_rst = 1'b0;
    chk("rst_halted", halted, 1); chk("rst_pc", pc, 0); chk("rst_acc", acc, 0);
    chk("rst_z", z, 1); chk("rst_n", n, 0); chk("rst_c", c, 0); chk("rst_rdata", ld_rdata, 0);
    chk("w_rst_halted", w_halted, 1); chk("w_rst_z", w_z, 1); chk("w_rst_rdata", w_rdata, 0);
    wr(8'h05, 8'hA5); rd(8'h05, rv); chk("host_rd5", rv, 8'hA5);

    // LDA 80; ADD 81; STA 82; HLT
    wr(8'h80, 8'h7F); wr(8'h81, 8'h01);
    wr(8'h00, 8'h20); wr(8'h01, 8'h80); wr(8'h02, 8'h30); wr(8'h03, 8'h81);
    wr(8'h04, 8'h10); wr(8'h05, 8'h82); wr(8'h06, 8'hF0);
    run_wait(100, cyc);
    chk("arith_cyc", cyc, 29); chk("arith_halted", halted, 1); chk("arith_acc", acc, 8'h80);
    chk("arith_n", n, 1); chk("arith_z", z, 0); chk("arith_c", c, 0); chk("arith_pc", pc, 7);
    rd(8'h82, rv); chk("arith_mem82", rv, 8'h80);

    do_reset();
    wr(8'h00, 8'hA0); wr(8'h01, 8'h10); wr(8'h10, 8'hF0);
    run_wait(100, cyc);
    chk("jz_taken_cyc", cyc, 11); chk("jz_taken_pc", pc, 8'h11);

    do_reset();
    wr(8'h00, 8'h20); wr(8'h01, 8'h30); wr(8'h30, 8'h01);
    wr(8'h02, 8'hA0); wr(8'h03, 8'h10); wr(8'h04, 8'hF0);
    run_wait(100, cyc);
    chk("jz_fall_cyc", cyc, 17); chk("jz_fall_pc", pc, 8'h05); chk("jz_fall_acc", acc, 1);

    // PC wrap: halt at FE leaves PC=FF, then NOP at FF wraps to HLT at 00.
    do_reset();
    wr(8'h00, 8'h80); wr(8'h01, 8'hFE); wr(8'hFE, 8'hF0); wr(8'hFF, 8'h00);
    run_wait(100, cyc);
    chk("wrap1_cyc", cyc, 11); chk("wrap1_pc", pc, 8'hFF);
    wr(8'h00, 8'hF0);
    run_wait(100, cyc);
    chk("wrap2_cyc", cyc, 9); chk("wrap2_pc", pc, 8'h01);
    // LDA 40(FF); ADD 41(02); JC 0A; then NOP-word / HLT
    wr(8'h01, 8'h20); wr(8'h02, 8'h40); wr(8'h40, 8'hFF); wr(8'h03, 8'h30); wr(8'h04, 8'h41);
    wr(8'h41, 8'h02); wr(8'h05, 8'hB0); wr(8'h06, 8'h0A); wr(8'h07, 8'hF0); wr(8'h0A, 8'hF0);
    run_wait(100, cyc);
    chk("carry_acc", acc, 8'h01); chk("carry_z", z, 0); chk("carry_n", n, 0);
`ifdef NEANDER_CARRY_EN
    chk("carry_c", c, 1); chk("jc_cyc", cyc, 27); chk("jc_pc", pc, 8'h0B);
`else
    chk("carry_c", c, 0); chk("opb_cyc", cyc, 29); chk("opb_pc", pc, 8'h08);
`endif

    // Operand of an instruction at FF is read from address 00.
    do_reset();
    wr(8'h00, 8'h80); wr(8'h01, 8'hFF); wr(8'hFF, 8'h20); wr(8'h80, 8'h5A);
    run_wait(100, cyc);
    chk("opwrap_cyc", cyc, 19); chk("opwrap_acc", acc, 8'h5A); chk("opwrap_pc", pc, 8'h02);

    // Host write coinciding with run lands; host writes while running are dropped.
    do_reset();
    wr(8'h90, 8'h33); wr(8'h00, 8'h00); wr(8'h01, 8'h00); wr(8'h02, 8'h00); wr(8'h03, 8'hF0);
    run = 1'b1; ld_we = 1'b1; ld_addr = 8'h02; ld_data = 8'hF0;
    @(negedge clk);
    run = 1'b0; ld_addr = 8'h90; ld_data = 8'h55;
    repeat (3) @(negedge clk);
    ld_we = 1'b0;
    cyc = 4;
    while (!halted && cyc < 60) begin @(negedge clk); cyc++; end
    chk("gate_cyc", cyc, 13); chk("gate_pc", pc, 8'h03);
    rd(8'h90, rv); chk("gate_mem90", rv, 8'h33);

    // Reset while STA sits in EX0.
    do_reset();
    wr(8'h91, 8'h77); wr(8'h00, 8'h10); wr(8'h01, 8'h91);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_halted", halted, 1); chk("abort_pc", pc, 0);
    rd(8'h91, rv); chk("abort_mem91", rv, 8'h77);

    // 16/10 build: NOT then HLT, opcode in bits 15:12.
    w_we = 1'b1; w_addr = 10'd0; w_data = 16'h6ABC;
    @(negedge clk);
    w_addr = 10'd1; w_data = 16'hF123;
    @(negedge clk);
    w_we = 1'b0; w_run = 1'b1;
    @(negedge clk);
    w_run = 1'b0;
    for (int k = 0; k < 20 && !w_halted; k++) @(negedge clk);
    chk("w_halted", w_halted, 1); chk("w_acc", w_acc, 16'hFFFF); chk("w_n", w_n, 1);
    chk("w_z", w_z, 0); chk("w_c", w_c, 0); chk("w_pc", w_pc, 10'd2);

    // Random memory images, state carried across runs.
    do_reset();
    m_acc = 8'h00; m_pc = 8'h00; m_n = 1'b0; m_z = 1'b1; m_c = 1'b0;
    for (int t = 0; t < 16; t++) begin
      sa = m_acc; sp = m_pc; sn = m_n; sz = m_z; sc = m_c;
      ok = 1'b0; mcyc = 0;
      for (int tries = 0; tries < 50 && !ok; tries++) begin
        m_acc = sa; m_pc = sp; m_n = sn; m_z = sz; m_c = sc;
        for (int a = 0; a < 256; a++) begin
          init[a]  = ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'($urandom);
          m_mem[a] = init[a];
        end
        model_run(ok, mcyc);
      end
      chk("rnd_gen", ok, 1);
      for (int a = 0; a < 256; a++) wr(8'(a), init[a]);
      run_wait(mcyc + 20, cyc);
      chk("rnd_halted", halted, 1); chk("rnd_cyc", cyc, mcyc + 1);
      chk("rnd_acc", acc, m_acc); chk("rnd_pc", pc, m_pc);
      chk("rnd_n", n, m_n); chk("rnd_z", z, m_z); chk("rnd_c", c, m_c);
      for (int a = 0; a < 256; a++) begin
        rd(8'(a), rv);
        chk("rnd_mem", rv, m_mem[a]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/neander_core_p.md
Name: neander_core_p

Overview:
- Parametrised next-generation Neander accumulator CPU with data width and address width as parameters.
- Internal single-port-write memory holding program and data.
- Adds an explicit HALTED state with a run control, plus a program-load/inspect port so the bench or host can fill memory without hierarchical access.
- Sits as the top-level processor core; a later SoC wraps it.

Parameters:
DATA_W, 8, accumulator/memory word width; must be >= 8 and >= ADDR_W.
ADDR_W, 8, address width; memory depth is 2**ADDR_W words.

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_rst  in  1  synchronous active-high reset.
i_run  in  1  single-cycle pulse; leaves HALTED and starts fetching at the current PC.
i_ld_we  in  1  host write enable; honoured only while HALTED.
i_ld_addr  in  ADDR_W  host read/write address.
i_ld_data  in  DATA_W  host write data.
o_ld_rdata  out  DATA_W  mem[i_ld_addr] registered, 1-cycle latency, valid in any state.
o_acc  out  DATA_W  accumulator.
o_pc  out  ADDR_W  program counter.
o_n  out  1  negative flag.
o_z  out  1  zero flag.
o_c  out  1  carry flag (see Optional Feature).
o_halted  out  1  high while in HALTED.

Behaviour:
- Reset:
  - Memory contents are not reset.
  - ACC=0, PC=0, N=0, Z=1, C=0, o_ld_rdata=0, state=HALTED, o_halted=1.
- Reset mid-instruction aborts the instruction. No memory write or register update from the aborted instruction takes effect.
- Instruction format:
  - Opcode = instr[DATA_W-1:DATA_W-4]; remaining bits are ignored.
  - Memory and jump ops take one operand word at PC+1. The effective address is operand[ADDR_W-1:0].
- Opcodes: 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 8 JMP, 9 JN, A JZ, F HLT. All others execute as NOP.
- States: HALTED, F0, F1, F2, DEC, RD, AD, EX0, EX1, JP.
  - F0: REM<=PC.
  - F1: RDM<=mem[REM], PC++.
  - F2: RI<=RDM.
  - DEC branches on the opcode:
    - NOP/undefined or NOT: NOT loads ACC<=~ACC and updates N,Z. Next state F0 (4 cycles total).
    - JN with N=0, or JZ with Z=0: PC++ to skip the operand. Next state F0 (4 cycles).
    - HLT: next state HALTED. PC points past HLT (3-cycle fetch + DEC).
    - Otherwise: REM<=PC, then RD.
  - RD: RDM<=mem[REM]. For non-jumps, PC++ and next state AD. For jumps, next state JP.
  - JP: PC<=RDM[ADDR_W-1:0]. Next state F0 (6 cycles total).
  - AD: REM<=RDM[ADDR_W-1:0].
  - EX0: STA loads RDM<=ACC; others load RDM<=mem[REM].
  - EX1: STA writes mem[REM]<=RDM. LDA/ADD/OR/AND load ACC<=result and update N,Z. Next state F0 (8 cycles total).
- Flags:
  - N = result MSB; Z = (result==0).
  - STA, NOP and jumps leave flags unchanged.
- Arithmetic: ADD is modulo 2**DATA_W.
- Wrap-around: PC increment wraps from 2**ADDR_W-1 to 0. An operand fetch at the last address reads address 0.
- Run control:
  - i_run is ignored outside HALTED.
  - i_run and i_ld_we in the same HALTED cycle: the write completes, then F0 is entered.
  - i_ld_we outside HALTED is ignored (no memory change).
- Memory write priority: core STA write and host write can never coincide. The host write is gated by HALTED.
- Read-during-write on the host port returns the old data.

Optional Feature:
Macro NEANDER_CARRY_EN.
- Defined:
  - ADD sets C to the carry-out of bit DATA_W-1.
  - LDA/OR/AND/NOT/STA leave C unchanged.
  - Opcode B = JC, a conditional jump on C=1 with the same timing as JN/JZ.
- Undefined:
  - C stays 0 and o_c is tied 0.
  - Opcode B executes as NOP (4 cycles). The following word is then fetched as an instruction.

Test Plan:
- Reset: assert i_rst for 2 cycles -> o_halted=1, o_pc=0, o_acc=0, o_z=1, o_n=0. Then load via the host port and read back mem[5] -> o_ld_rdata equals the written value one cycle later.
- Arithmetic program (DATA_W=8), data at 0x80=0x7F and 0x81=0x01. Program: LDA 80; ADD 81; STA 82; HLT; then pulse i_run -> mem[0x82]=0x80, N=1, Z=0, o_halted=1, o_pc=7. Total cycles from i_run to o_halted are 8+8+8+4 (±1 for the HALTED exit cycle).
- Branches: with ACC=0 (Z=1), JZ 10 -> PC=0x10 after 6 cycles. With ACC=1, JZ 10 -> falls through in 4 cycles and PC advances by 2.
- Wrap-around: start PC=0xFF (ADDR_W=8) with NOP at 0xFF -> next fetch from 0x00. ADD of 0xFF+0x02 -> ACC=0x01; with NEANDER_CARRY_EN, C=1 and JC is taken.
- Gating and reset: i_ld_we while running -> memory unchanged. i_rst asserted during EX0 of STA -> target word unchanged, state HALTED.
- Parametrised build: DATA_W=16, ADDR_W=10; NOT on ACC=0x0000 -> ACC=0xFFFF, N=1. Opcode is taken from bits 15:12.
